// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: word width, bytes per
// word and the state encodings of the loader and its serial receiver.
package prog_loader_pkg;

  localparam int REGWIDTH       = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a double-flop input synchronizer and mid-bit
// sampling driven by a down-counter.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | falling edge seen, waiting for the start-bit midpoint
// RX_DATA  | sampling 8 data bits LSB-first at mid-bit
// RX_STOP  | waiting for the stop-bit midpoint, then valid/frame_err
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tick;
  logic             fall;

  assign tick = (cnt_q == '0);
  assign fall = prev_q & ~sync2_q;

  // State, synchronizer and datapath registers; reset leaves the line idle-high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; a start bit that is high again at its midpoint is a glitch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && (bit_q == 3'd7)) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Bit timer, bit index and shift register updates.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = tick ? cnt_q : cnt_q - CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      RX_IDLE: if (fall) cnt_d = HALF_LOAD;
      RX_START: begin
        if (tick) begin
          cnt_d = FULL_LOAD;
          bit_d = '0;
        end
      end
      RX_DATA: begin
        if (tick) begin
          shreg_d = {sync2_q, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: single-cycle strobes at the stop-bit midpoint.
  always_comb begin
    data      = shreg_q;
    valid     = (state_q == RX_STOP) && tick && sync2_q;
    frame_err = (state_q == RX_STOP) && tick && !sync2_q;
  end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: holds the CPU in reset, receives a little-endian
// word count followed by that many little-endian words, and writes them
// into instruction memory from address 0.
//
// state   | meaning
// ST_RUN  | CPU running, waiting for load_req
// ST_LEN  | assembling the 4-byte word count
// ST_DATA | assembling words and writing them to instruction memory
// ST_DONE | one-cycle pause before releasing the CPU
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 868,
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                load_req,
  output logic                cpu_hold,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [REGWIDTH-1:0] imem_wdata,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BC_W  = $clog2(BYTES_PER_WORD);
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BC_W-1:0]   BC_LAST    = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [REGWIDTH:0] MAX_WORDS  = (REGWIDTH + 1)'(1) << ADDR_W;

  ld_state_e           state_q, state_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [REGWIDTH-1:0] asm_q, asm_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ferr;
  logic [REGWIDTH-1:0] assembled;
  logic [ADDR_W:0]     words_inc;
  logic                in_load, last_byte, timed_out, abort, len_zero, len_over;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  // New bytes enter at the top so the first byte ends up in bits 7:0.
  assign assembled = {rx_data, asm_q[REGWIDTH-1:8]};
  assign words_inc = words_q + (ADDR_W + 1)'(1);
  assign in_load   = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign last_byte = rx_valid && (byte_cnt_q == BC_LAST);
  assign timed_out = in_load && (timer_q == '0) && !rx_valid;
  assign abort     = in_load && (rx_ferr || timed_out);
  assign len_zero  = (assembled == '0);
  assign len_over  = ({1'b0, assembled} > MAX_WORDS);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      words_q    <= '0;
      len_q      <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state logic; completion is detected as the last write retires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: if (load_req) state_d = ST_LEN;
      ST_LEN: begin
        if (abort) state_d = ST_RUN;
        else if (last_byte) begin
          if (len_zero)      state_d = ST_DONE;
          else if (len_over) state_d = ST_RUN;
          else               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (abort) state_d = ST_RUN;
        else if (we_q && (words_inc == len_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Byte assembly, write strobe, address/count advance and idle timeout.
  always_comb begin
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    words_d    = words_q;
    len_d      = len_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = (timer_q == '0) ? timer_q : timer_q - TMR_W'(1);
    unique case (state_q)
      ST_RUN: begin
        if (load_req) begin
          err_d      = 1'b0;
          addr_d     = '0;
          words_d    = '0;
          len_d      = '0;
          byte_cnt_d = '0;
          timer_d    = TMR_RELOAD;
        end
      end
      ST_LEN, ST_DATA: begin
        if (abort) begin
          err_d = 1'b1;
        end else if (rx_valid) begin
          timer_d    = TMR_RELOAD;
          asm_d      = assembled;
          byte_cnt_d = last_byte ? '0 : byte_cnt_q + BC_W'(1);
          if (last_byte && (state_q == ST_LEN)) begin
            len_d = assembled[ADDR_W:0];
            err_d = len_over;
          end
          if (last_byte && (state_q == ST_DATA)) we_d = 1'b1;
        end
        if (we_q) begin
          addr_d  = addr_q + ADDR_W'(1);
          words_d = words_inc;
        end
      end
      default: ;
    endcase
  end

  // Outputs: the CPU is held for the whole time the loader is not in RUN.
  always_comb begin
    cpu_hold     = (state_q != ST_RUN);
    busy         = (state_q != ST_RUN);
    imem_we      = we_q;
    imem_addr    = addr_q;
    imem_wdata   = asm_q;
    err          = err_q;
    words_loaded = words_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus randomized loads checked
// against a byte-stream model of the load protocol.
module tb_prog_loader;

  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          load_req = 1'b0;
  logic          cpu_hold, imem_we, busy, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  prog_loader #(
    .CLKS_PER_BIT  (CPB),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .load_req    (load_req),
    .cpu_hold    (cpu_hold),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            last_we_cyc = -1;
  int            fall_cyc = -1;
  int            we_run = 0;
  int            max_we_run = 0;
  int            rxv_cnt = 0;
  logic          hold_prev = 1'b0;

  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          exp_err;
  int            exp_words;

  always @(posedge clk) cyc++;

  // Observe write strobes, hold release and receiver strobes mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      last_we_cyc = cyc;
      we_run++;
      if (we_run > max_we_run) max_we_run = we_run;
    end else begin
      we_run = 0;
    end
    if (hold_prev === 1'b1 && cpu_hold === 1'b0) fall_cyc = cyc;
    hold_prev = cpu_hold;
    if (dut.u_rx.valid === 1'b1) rxv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected outcome of a load from the byte stream alone: count, then words.
  task automatic model(input logic [7:0] bs[$]);
    longint unsigned n;
    int nw;
    exp_addr.delete();
    exp_data.delete();
    exp_err   = 1'b0;
    exp_words = 0;
    n = longint'(bs[0]) + longint'(bs[1]) * 256 + longint'(bs[2]) * 65536
        + longint'(bs[3]) * 16777216;
    if (n > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    nw = 0;
    while (nw < n && (4 + 4 * nw + 3) < bs.size()) begin
      exp_addr.push_back(AW'(nw));
      exp_data.push_back(32'(longint'(bs[4 + 4 * nw]) + longint'(bs[5 + 4 * nw]) * 256
                           + longint'(bs[6 + 4 * nw]) * 65536
                           + longint'(bs[7 + 4 * nw]) * 16777216));
      nw++;
    end
    exp_words = nw;
    if (nw < n) exp_err = 1'b1;
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    last_we_cyc = -1;
    fall_cyc    = -1;
    max_we_run  = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_load(input string tag);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk({tag, "_hold_on"}, cpu_hold, 1'b1);
    chk({tag, "_busy_on"}, busy, 1'b1);
  endtask

  task automatic send_seq(input logic [7:0] bs[$], input int gapmax);
    foreach (bs[i]) begin
      send_byte(bs[i], 1'b1);
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwr"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_hold"}, cpu_hold, 1'b0);
    chk({tag, "_words"}, words_loaded, exp_words);
    chk({tag, "_we_width"}, max_we_run, (exp_addr.size() > 0) ? 1 : 0);
    if (!exp_err && exp_addr.size() > 0)
      chk({tag, "_release"}, fall_cyc - last_we_cyc, 2);
  endtask

  initial begin
    logic [7:0] bs[$];
    int rxv0;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_words", words_loaded, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Two-word load
    clear_mon();
    bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    model(bs);
    pulse_load("two");
    send_seq(bs, 0);
    wait_idle("two");
    check_result("two");
    if (got_data.size() == 2) begin
      chk("two_word0", got_data[0], 32'h00100513);
      chk("two_word1", got_data[1], 32'h00200593);
    end

    // Zero-length load
    clear_mon();
    bs = '{8'h00, 8'h00, 8'h00, 8'h00};
    model(bs);
    pulse_load("zero");
    send_seq(bs, 3);
    wait_idle("zero");
    check_result("zero");

    // Count one beyond the memory size
    clear_mon();
    bs = '{8'h11, 8'h00, 8'h00, 8'h00};
    model(bs);
    pulse_load("over");
    send_seq(bs, 3);
    wait_idle("over");
    check_result("over");

    // Idle timeout mid-word, then a new request clears err
    clear_mon();
    bs = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05};
    pulse_load("tmo");
    send_seq(bs, 0);
    repeat (1500) @(negedge clk);
    chk("tmo_not_early", busy, 1'b1);
    repeat (700) @(negedge clk);
    chk("tmo_err", err, 1'b1);
    chk("tmo_hold", cpu_hold, 1'b0);
    chk("tmo_nwr", got_addr.size(), 0);
    pulse_load("tmo2");
    chk("tmo2_err_clr", err, 1'b0);
    bs = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(bs, 0);
    wait_idle("tmo2");
    chk("tmo2_err", err, 1'b0);

    // Framing error on the first byte of the second word
    clear_mon();
    bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model(bs);
    pulse_load("ferr");
    send_seq(bs, 2);
    send_byte(8'h55, 1'b0);
    wait_idle("ferr");
    check_result("ferr");
    chk("ferr_err_set", err, 1'b1);

    // Short low glitch must not produce a byte
    clear_mon();
    pulse_load("glitch");
    rxv0 = rxv_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_no_valid", rxv_cnt - rxv0, 0);
    bs = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(bs, 0);
    wait_idle("glitch");
    chk("glitch_err", err, 1'b0);
    chk("glitch_nwr", got_addr.size(), 0);

    // Reset between the 2nd and 3rd data bytes
    clear_mon();
    pulse_load("mrst");
    bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_seq(bs, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_hold", cpu_hold, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_we", imem_we, 1'b0);
    chk("mrst_addr", imem_addr, 0);
    chk("mrst_words", words_loaded, 0);
    rst = 1'b1;
    bs = '{8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(bs, 0);
    repeat (50) @(negedge clk);
    chk("mrst_nwr", got_addr.size(), 0);
    chk("mrst_idle", busy, 1'b0);

    // Second load_req during a load is ignored
    clear_mon();
    bs = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model(bs);
    pulse_load("req2");
    send_byte(bs[0], 1'b1);
    send_byte(bs[1], 1'b1);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    send_seq(bs[2:$], 0);
    wait_idle("req2");
    check_result("req2");

    // Randomized loads
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      bs.delete();
      if ($urandom_range(0, 3) == 0) n = $urandom_range(17, 32'h7FFF_FFFF);
      else n = $urandom_range(1, 5);
      for (int b = 0; b < 4; b++) bs.push_back(8'((n >> (8 * b)) & 255));
      if (n <= (1 << AW))
        for (int b = 0; b < 4 * n; b++) bs.push_back(8'($urandom_range(0, 255)));
      model(bs);
      pulse_load($sformatf("rnd%0d", it));
      send_seq(bs, 20);
      wait_idle($sformatf("rnd%0d", it));
      check_result($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
